// File: rtl/btb_update.sv
// Branch-resolution unit: detects mispredicts on a two-slot resolve port, issues a
// one-cycle redirect, and queues BTB corrections in a coalescing write FIFO.
module btb_update #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        validA,
    input  logic        validB,
    input  logic [15:0] PCA,
    input  logic [15:0] PCB,
    input  logic        predTakenA,
    input  logic        predTakenB,
    input  logic [15:0] predTargetA,
    input  logic [15:0] predTargetB,
    input  logic        takenA,
    input  logic        takenB,
    input  logic [15:0] actTargetA,
    input  logic [15:0] actTargetB,
    input  logic        flushDone,
    input  logic        wrReady,
    output logic        redirect,
    output logic [15:0] redirectPC,
    output logic        WE,
    output logic [15:0] PCW,
    output logic [15:0] targetW,
    output logic [15:0] mispredCount,
    output logic [7:0]  dropCount
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic {
        NORMAL = 1'b0,
        FLUSH  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_mem_pc  [DEPTH];
    logic [15:0] r_mem_tgt [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic        r_redirect;
    logic [15:0] r_redirect_pc;
    logic [15:0] r_mispred_cnt;
    logic [7:0]  r_drop_cnt;

    logic [15:0] w_pred_next_a, w_act_next_a;
    logic [15:0] w_pred_next_b, w_act_next_b;
    logic        w_misp_a, w_misp_b, w_misp;
    logic [15:0] w_new_pc, w_new_tgt;
    logic        w_empty, w_full, w_pop;
    logic [AW-1:0] w_tail_ptr;
    logic        w_coalesce, w_push, w_drop;

    assign w_pred_next_a = predTakenA ? predTargetA : PCA + 16'd2;
    assign w_act_next_a  = takenA     ? actTargetA  : PCA + 16'd2;
    assign w_pred_next_b = predTakenB ? predTargetB : PCB + 16'd2;
    assign w_act_next_b  = takenB     ? actTargetB  : PCB + 16'd2;

    // Slot B is wrong-path whenever slot A mispredicts, so it is masked off.
    assign w_misp_a = validA && (r_state == NORMAL) && (w_pred_next_a != w_act_next_a);
    assign w_misp_b = validB && (r_state == NORMAL) && !w_misp_a && (w_pred_next_b != w_act_next_b);
    assign w_misp   = w_misp_a || w_misp_b;

    assign w_new_pc  = w_misp_a ? PCA : PCB;
    assign w_new_tgt = w_misp_a ? w_act_next_a : w_act_next_b;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_CNT);
    assign w_pop      = !w_empty && wrReady;
    assign w_tail_ptr = r_wr_ptr - AW'(1);

    // A lone entry leaving this cycle cannot absorb the new update; it enqueues instead.
    assign w_coalesce = w_misp && !w_empty && (r_mem_pc[w_tail_ptr] == w_new_pc)
                        && !(w_pop && (r_count == (AW + 1)'(1)));
    assign w_push     = w_misp && !w_coalesce && (!w_full || w_pop);
    assign w_drop     = w_misp && !w_coalesce && w_full && !w_pop;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            NORMAL:  if (w_misp)    w_state_nxt = FLUSH;
            FLUSH:   if (flushDone) w_state_nxt = NORMAL;
            default: w_state_nxt = NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= NORMAL;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_mispred_cnt <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_redirect    <= w_misp;
            r_redirect_pc <= w_misp ? w_new_tgt : '0;
            if (w_misp)
                r_mispred_cnt <= r_mispred_cnt + 16'd1;
            if (w_drop && (r_drop_cnt != 8'hFF))
                r_drop_cnt <= r_drop_cnt + 8'd1;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]  <= w_new_pc;
            r_mem_tgt[r_wr_ptr] <= w_new_tgt;
        end
        if (w_coalesce)
            r_mem_tgt[w_tail_ptr] <= w_new_tgt;
    end

    assign redirect     = r_redirect;
    assign redirectPC   = r_redirect_pc;
    assign WE           = w_pop;
    assign PCW          = w_empty ? '0 : r_mem_pc[r_rd_ptr];
    assign targetW      = w_empty ? '0 : r_mem_tgt[r_rd_ptr];
    assign mispredCount = r_mispred_cnt;
    assign dropCount    = r_drop_cnt;

endmodule

// File: tb/tb_btb_update.sv
// Self-checking bench for btb_update: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_btb_update;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        validA, validB;
    logic [15:0] PCA, PCB;
    logic        predTakenA, predTakenB;
    logic [15:0] predTargetA, predTargetB;
    logic        takenA, takenB;
    logic [15:0] actTargetA, actTargetB;
    logic        flushDone, wrReady;
    logic        redirect;
    logic [15:0] redirectPC;
    logic        WE;
    logic [15:0] PCW, targetW;
    logic [15:0] mispredCount;
    logic [7:0]  dropCount;

    always #5 clk = ~clk;

    btb_update #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .validA(validA), .validB(validB),
        .PCA(PCA), .PCB(PCB),
        .predTakenA(predTakenA), .predTakenB(predTakenB),
        .predTargetA(predTargetA), .predTargetB(predTargetB),
        .takenA(takenA), .takenB(takenB),
        .actTargetA(actTargetA), .actTargetB(actTargetB),
        .flushDone(flushDone), .wrReady(wrReady),
        .redirect(redirect), .redirectPC(redirectPC),
        .WE(WE), .PCW(PCW), .targetW(targetW),
        .mispredCount(mispredCount), .dropCount(dropCount)
    );

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] tgt;
    } ent_t;

    ent_t        mq[$];
    bit          m_flush;
    bit          m_redir;
    logic [15:0] m_rpc;
    logic [15:0] m_mcnt;
    int          m_dcnt;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] next_pc(input logic tk, input logic [15:0] tgt, input logic [15:0] pc);
        return tk ? tgt : 16'(pc + 16'd2);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_flush = 0;
        m_redir = 0;
        m_rpc   = '0;
        m_mcnt  = '0;
        m_dcnt  = 0;
    endtask

    task automatic model_step();
        bit          pop, misp, coal;
        logic [15:0] pc, tgt;
        ent_t        e;
        pop  = (mq.size() > 0) && wrReady;
        misp = 0;
        coal = 0;
        pc   = '0;
        tgt  = '0;
        if (!m_flush) begin
            if (validA && next_pc(predTakenA, predTargetA, PCA) != next_pc(takenA, actTargetA, PCA)) begin
                misp = 1; pc = PCA; tgt = next_pc(takenA, actTargetA, PCA);
            end else if (validB && next_pc(predTakenB, predTargetB, PCB) != next_pc(takenB, actTargetB, PCB)) begin
                misp = 1; pc = PCB; tgt = next_pc(takenB, actTargetB, PCB);
            end
        end
        if (m_flush) begin
            if (flushDone) m_flush = 0;
        end else if (misp) begin
            m_flush = 1;
        end
        m_redir = misp;
        m_rpc   = tgt;
        if (misp) m_mcnt = m_mcnt + 16'd1;
        if (misp && mq.size() > 0 && mq[mq.size()-1].pc == pc && !(pop && mq.size() == 1)) begin
            e = mq[mq.size()-1];
            e.tgt = tgt;
            mq[mq.size()-1] = e;
            coal = 1;
        end
        if (pop) void'(mq.pop_front());
        if (misp && !coal) begin
            if (mq.size() < DEPTH) mq.push_back('{pc: pc, tgt: tgt});
            else if (m_dcnt < 255) m_dcnt++;
        end
    endtask

    // Called just after a falling edge with this cycle's inputs already driven.
    task automatic tick();
        bit exp_we;
        #1;
        exp_we = (mq.size() > 0) && wrReady;
        chk("redirect", {31'b0, redirect}, {31'b0, m_redir});
        if (m_redir) chk("redirectPC", {16'b0, redirectPC}, {16'b0, m_rpc});
        chk("WE", {31'b0, WE}, {31'b0, exp_we});
        if (exp_we) begin
            chk("PCW", {16'b0, PCW}, {16'b0, mq[0].pc});
            chk("targetW", {16'b0, targetW}, {16'b0, mq[0].tgt});
        end
        chk("mispredCount", {16'b0, mispredCount}, {16'b0, m_mcnt});
        chk("dropCount", {24'b0, dropCount}, 32'(m_dcnt));
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_idle();
        validA = 0; validB = 0;
        PCA = '0; PCB = '0;
        predTakenA = 0; predTakenB = 0;
        predTargetA = '0; predTargetB = '0;
        takenA = 0; takenB = 0;
        actTargetA = '0; actTargetB = '0;
        flushDone = 0;
    endtask

    task automatic set_a(input logic [15:0] pc, input logic pt, input logic [15:0] ptgt,
                         input logic tk, input logic [15:0] atgt);
        validA = 1; PCA = pc; predTakenA = pt; predTargetA = ptgt;
        takenA = tk; actTargetA = atgt;
    endtask

    task automatic misp_then_flush(input logic [15:0] pc, input logic [15:0] tgt);
        set_idle();
        set_a(pc, 1'b0, 16'h0, 1'b1, tgt);
        tick();
        set_idle();
        flushDone = 1;
        tick();
        set_idle();
    endtask

    initial begin
        model_reset();
        set_idle();
        wrReady = 1;
        rst_n   = 0;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_redirect", {31'b0, redirect}, 32'd0);
        chk("rst_WE", {31'b0, WE}, 32'd0);
        chk("rst_mispredCount", {16'b0, mispredCount}, 32'd0);
        chk("rst_dropCount", {24'b0, dropCount}, 32'd0);
        rst_n = 1;
        @(negedge clk);

        // Not-predicted taken branch
        set_a(16'h0100, 1'b0, 16'h0, 1'b1, 16'h0200);
        wrReady = 1;
        tick();
        set_idle();
        #1;
        chk("t1_redirect", {31'b0, redirect}, 32'd1);
        chk("t1_redirectPC", {16'b0, redirectPC}, 32'h0200);
        chk("t1_WE", {31'b0, WE}, 32'd1);
        chk("t1_PCW", {16'b0, PCW}, 32'h0100);
        chk("t1_targetW", {16'b0, targetW}, 32'h0200);
        chk("t1_mispredCount", {16'b0, mispredCount}, 32'd1);
        tick();
        flushDone = 1;
        tick();
        set_idle();

        // Predicted taken but fell through, with a wrong-path slot-B mispredict
        set_a(16'h0040, 1'b1, 16'h0080, 1'b0, 16'h0);
        validB = 1; PCB = 16'h0500; predTakenB = 0; takenB = 1; actTargetB = 16'h0600;
        tick();
        set_idle();
        #1;
        chk("t2_redirectPC", {16'b0, redirectPC}, 32'h0042);
        chk("t2_PCW", {16'b0, PCW}, 32'h0040);
        chk("t2_targetW", {16'b0, targetW}, 32'h0042);
        chk("t2_mispredCount", {16'b0, mispredCount}, 32'd2);
        tick();
        flushDone = 1;
        #1;
        chk("t2_noB_WE", {31'b0, WE}, 32'd0);
        tick();
        set_idle();

        // Resolutions ignored while flushing, including on the flushDone cycle
        set_a(16'h0700, 1'b0, 16'h0, 1'b1, 16'h0800);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_idle();
            set_a(16'h0710 + 16'(i * 4), 1'b0, 16'h0, 1'b1, 16'h0900);
            tick();
            #1;
            chk("t3_flush_redirect", {31'b0, redirect}, 32'd0);
        end
        set_a(16'h0730, 1'b0, 16'h0, 1'b1, 16'h0900);
        flushDone = 1;
        tick();
        #1;
        chk("t3_fd_redirect", {31'b0, redirect}, 32'd0);
        chk("t3_fd_WE", {31'b0, WE}, 32'd0);
        set_idle();
        set_a(16'h0720, 1'b0, 16'h0, 1'b1, 16'h0A00);
        tick();
        set_idle();
        #1;
        chk("t3_accept_redirect", {31'b0, redirect}, 32'd1);
        chk("t3_accept_redirectPC", {16'b0, redirectPC}, 32'h0A00);
        chk("t3_mispredCount", {16'b0, mispredCount}, 32'd4);
        tick();
        flushDone = 1;
        tick();
        set_idle();
        tick();

        // Overflow: DEPTH+1 distinct updates with the write port blocked
        wrReady = 0;
        for (int k = 0; k <= DEPTH; k++)
            misp_then_flush(16'h1000 + 16'(k * 4), 16'h2000 + 16'(k));
        #1;
        chk("t4_dropCount", {24'b0, dropCount}, 32'd1);
        wrReady = 1;
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            chk("t4_drain_WE", {31'b0, WE}, 32'd1);
            chk("t4_drain_PCW", {16'b0, PCW}, 32'h1000 + 32'(k * 4));
            chk("t4_drain_targetW", {16'b0, targetW}, 32'h2000 + 32'(k));
            tick();
        end
        #1;
        chk("t4_empty_WE", {31'b0, WE}, 32'd0);
        tick();

        // Coalescing two updates to the same PC
        wrReady = 0;
        misp_then_flush(16'h0010, 16'h0300);
        misp_then_flush(16'h0010, 16'h0400);
        wrReady = 1;
        #1;
        chk("t5_WE", {31'b0, WE}, 32'd1);
        chk("t5_PCW", {16'b0, PCW}, 32'h0010);
        chk("t5_targetW", {16'b0, targetW}, 32'h0400);
        tick();
        #1;
        chk("t5_single_WE", {31'b0, WE}, 32'd0);
        tick();

        // dropCount saturation
        wrReady = 0;
        for (int k = 0; k < DEPTH; k++)
            misp_then_flush(16'h3000 + 16'(k * 4), 16'h3100);
        for (int k = 0; k < 260; k++)
            misp_then_flush(16'h3F00, 16'h3200 + 16'(k));
        #1;
        chk("t6_dropSat", {24'b0, dropCount}, 32'd255);
        wrReady = 1;
        for (int k = 0; k <= DEPTH; k++) tick();

        // Asynchronous reset mid-flush with two queued entries
        wrReady = 0;
        misp_then_flush(16'h5000, 16'h5100);
        set_a(16'h5004, 1'b0, 16'h0, 1'b1, 16'h5200);
        tick();
        set_idle();
        wrReady = 1;
        #2;
        rst_n = 0;
        #1;
        chk("t7_rst_redirect", {31'b0, redirect}, 32'd0);
        chk("t7_rst_redirectPC", {16'b0, redirectPC}, 32'd0);
        chk("t7_rst_WE", {31'b0, WE}, 32'd0);
        chk("t7_rst_PCW", {16'b0, PCW}, 32'd0);
        chk("t7_rst_targetW", {16'b0, targetW}, 32'd0);
        chk("t7_rst_mispredCount", {16'b0, mispredCount}, 32'd0);
        chk("t7_rst_dropCount", {24'b0, dropCount}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t7_post_WE", {31'b0, WE}, 32'd0);
            tick();
        end

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            validA      = ($urandom_range(0, 1) == 1);
            validB      = ($urandom_range(0, 1) == 1);
            PCA         = 16'h0010 * 16'($urandom_range(1, 4));
            PCB         = 16'h0010 * 16'($urandom_range(1, 4));
            predTakenA  = ($urandom_range(0, 1) == 1);
            predTakenB  = ($urandom_range(0, 1) == 1);
            takenA      = ($urandom_range(0, 1) == 1);
            takenB      = ($urandom_range(0, 1) == 1);
            predTargetA = 16'h0100 * 16'($urandom_range(1, 3));
            predTargetB = 16'h0100 * 16'($urandom_range(1, 3));
            actTargetA  = 16'h0100 * 16'($urandom_range(1, 3));
            actTargetB  = 16'h0100 * 16'($urandom_range(1, 3));
            flushDone   = ($urandom_range(0, 3) == 0);
            wrReady     = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btb_update.md
BTB_UPDATE -- requirements
Module: btb_update

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the number of BTB-write FIFO entries (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have ports validA / validB, input, 1, branch resolved this cycle in slot A (older) / slot B (younger).
REQ-005 SHALL have ports PCA / PCB, input, 16, the branch PC per slot.
REQ-006 SHALL have ports predTakenA / predTakenB, input, 1, the fetch-time BTB hit per slot.
REQ-007 SHALL have ports predTargetA / predTargetB, input, 16, the fetch-time BTB target per slot.
REQ-008 SHALL have ports takenA / takenB, input, 1, the actual outcome per slot.
REQ-009 SHALL have ports actTargetA / actTargetB, input, 16, the actual taken target per slot.
REQ-010 SHALL have port flushDone, input, 1, front end has refetched from the redirect PC.
REQ-011 SHALL have port wrReady, input, 1, BTB write port free this cycle.
REQ-012 SHALL have port redirect, output, 1, mispredict redirect pulse.
REQ-013 SHALL have port redirectPC, output, 16, the correct next PC.
REQ-014 SHALL have ports WE / PCW / targetW, output, 1/16/16, the BTB write port.
REQ-015 SHALL have port mispredCount, output, 16, count of mispredicts; wraps.
REQ-016 SHALL have port dropCount, output, 8, count of updates lost to a full FIFO; saturates at 255.

Function
REQ-017 SHALL compute per slot predNext = predTaken ? predTarget : PC+2 and actNext = taken ? actTarget : PC+2, all arithmetic modulo 2^16.
REQ-018 SHALL flag a slot as mispredicted iff its valid is high, state is NORMAL and predNext != actNext.
REQ-019 SHALL, when slot A mispredicts, ignore slot B entirely in that cycle, since B is wrong-path.
REQ-020 SHALL, on a mispredict in cycle N, drive redirect=1 and redirectPC=actNext of the oldest mispredicting slot in cycle N+1 only.
REQ-021 SHALL use a two-state FSM, NORMAL and FLUSH.
REQ-022 SHALL, on a mispredict in NORMAL, transition to FLUSH.
REQ-023 SHALL, in FLUSH, ignore all resolutions, including those in the cycle where flushDone=1.
REQ-024 SHALL transition FLUSH->NORMAL on the edge where flushDone=1.
REQ-025 SHALL ignore flushDone while in NORMAL.
REQ-026 SHALL, on each mispredict, enqueue the entry {PC, actNext}, so that a not-taken correction writes PC+2.
REQ-027 SHALL increment mispredCount on each mispredict.
REQ-028 SHALL coalesce a new entry into the tail when the FIFO is non-empty and the tail PC equals the new PC: tail target is overwritten and count is unchanged.
REQ-029 SHALL not coalesce when the tail is also the head being popped this cycle; in that case the new entry enqueues normally.
REQ-030 SHALL drive WE = (FIFO non-empty) & wrReady, with PCW/targetW equal to the head entry; the head pops on that edge.
REQ-031 SHALL accept a push when the FIFO is full if a pop occurs in the same cycle.
REQ-032 SHALL, when the FIFO is full with no pop, still redirect, drop the update and increment dropCount (saturating).
REQ-033 SHALL preserve FIFO ordering with wrap-around read/write pointers, and a count of width log2(DEPTH)+1.

Reset
REQ-034 SHALL, while rst_n=0, immediately force state=NORMAL, redirect=0, redirectPC=0, WE=0, FIFO empty, mispredCount=0 and dropCount=0.
REQ-035 SHALL, on reset assertion mid-FLUSH or with a non-empty FIFO, discard all pending updates and the pending redirect.
REQ-036 SHALL begin accepting resolutions in the first cycle after rst_n rises.

Verification
REQ-037 SHALL verify: A: PC=0x0100, predTaken=0, taken=1, actTarget=0x0200, wrReady=1 -> next cycle redirect=1, redirectPC=0x0200, WE=1, PCW=0x0100, targetW=0x0200, mispredCount=1.
REQ-038 SHALL verify: A: PC=0x0040, predTaken=1, predTarget=0x0080, taken=0 -> redirectPC=0x0042, targetW=0x0042; a simultaneous slot-B mispredict produces no effect.
REQ-039 SHALL verify: in FLUSH, 3 mispredicting resolutions followed by flushDone=1 -> no redirect, no enqueue; a mispredict the cycle after flushDone is accepted.
REQ-040 SHALL verify: wrReady=0 with DEPTH+1 distinct-PC mispredicts (each followed by flushDone) -> dropCount=1; then wrReady=1 -> DEPTH writes in arrival order.
REQ-041 SHALL verify: wrReady=0 with two mispredicts on PC=0x0010 (targets 0x0300 then 0x0400) -> a single entry; drains as targetW=0x0400.
REQ-042 SHALL verify: rst_n dropped asynchronously mid-FLUSH with 2 queued entries -> outputs zero immediately; WE stays 0 after release.
